// File: rtl/scpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU; all strobes are registered one-cycle pulses.
// Optional build macro SCPU_SINGLE_STEP_EN adds dbg_step_en/dbg_step to release one instruction per step pulse.
module scpu_ctrl_fsm #(
    parameter int WAIT_MAX = 16,
    parameter int RET_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SCPU_SINGLE_STEP_EN
    input  logic             dbg_step_en,
    input  logic             dbg_step,
`endif
    input  logic [7:0]       fetch_ir,
    input  logic             mem_rdy,
    output logic             ctl_load_ir,
    output logic             ctl_load_dr,
    output logic             ctl_load_pc,
    output logic             ctl_inc_pc,
    output logic [1:0]       ctl_addr_sel,
    output logic             ctl_mem_wr,
    output logic             ctl_load_rd,
    output logic             ctl_halted,
    output logic             ctl_err,
    output logic [2:0]       ctl_state,
    output logic [RET_W-1:0] ctl_retired
);

    localparam int WW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_FETCH2 = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_JUMP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic             halted_q, halted_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             load_ir_q, load_ir_d;
    logic             load_dr_q, load_dr_d;
    logic             load_pc_q, load_pc_d;
    logic             inc_pc_q, inc_pc_d;
    logic             mem_wr_q, mem_wr_d;
    logic             load_rd_q, load_rd_d;
    logic             fetch_go, acc_state, acc_done, timeout;
`ifdef SCPU_SINGLE_STEP_EN
    logic             step_ok_q, step_ok_d;
`endif

    // An access state only listens to mem_rdy (and only counts waits) while it is allowed to proceed.
    always_comb begin
        fetch_go = 1'b1;
`ifdef SCPU_SINGLE_STEP_EN
        fetch_go = !dbg_step_en || step_ok_q;
`endif
        acc_state = (state_q == S_FETCH && fetch_go) || state_q == S_FETCH2 || state_q == S_MEM;
        acc_done  = acc_state && mem_rdy;
        timeout   = acc_state && !mem_rdy && (wait_q == WW'(WAIT_MAX - 1));
    end

    // Next-state process.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        err_d     = err_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        if (acc_state && !mem_rdy) wait_d = wait_q + WW'(1);

        case (state_q)
            S_RST:    if (!err_q) state_d = S_FETCH;
            S_FETCH:  if (acc_done) state_d = S_DECODE;
            S_DECODE: begin
                if (fetch_ir == 8'hFF) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    case (fetch_ir[7:6])
                        2'b00:   state_d = S_EXEC;
                        2'b10:   state_d = S_MEM;
                        default: state_d = S_FETCH2;
                    endcase
                end
            end
            S_FETCH2: if (acc_done) state_d = (fetch_ir[7:6] == 2'b11) ? S_JUMP : S_EXEC;
            S_EXEC: begin
                state_d   = S_FETCH;
                retired_d = retired_q + RET_W'(1);
            end
            S_MEM: begin
                if (acc_done) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + RET_W'(1);
                end
            end
            S_JUMP: begin
                state_d   = S_FETCH;
                retired_d = retired_q + RET_W'(1);
            end
            S_HALT:   state_d = S_HALT;
        endcase

        // The fault state shares encoding 0 with RST; err_q keeps it parked there.
        if (timeout) begin
            state_d = S_RST;
            err_d   = 1'b1;
        end

        if (state_d != state_q &&
            (state_d == S_FETCH || state_d == S_FETCH2 || state_d == S_MEM))
            wait_d = '0;

`ifdef SCPU_SINGLE_STEP_EN
        step_ok_d = dbg_step || (step_ok_q && !(state_q == S_FETCH && acc_done));
`endif
    end

    // Output process: strobe values to be registered at the coming edge.
    always_comb begin
        load_ir_d    = (state_q == S_FETCH) && acc_done;
        inc_pc_d     = (state_q == S_FETCH || state_q == S_FETCH2) && acc_done;
        load_dr_d    = (state_q == S_FETCH2) && acc_done;
        mem_wr_d     = (state_q == S_MEM) && acc_done && fetch_ir[5];
        load_rd_d    = (state_q == S_EXEC) || ((state_q == S_MEM) && acc_done && !fetch_ir[5]);
        load_pc_d    = (state_q == S_JUMP);
        ctl_addr_sel = (state_q == S_MEM) ? 2'b10 : 2'b00;
    end

    // State register process.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= S_RST;
            err_q     <= 1'b0;
            halted_q  <= 1'b0;
            wait_q    <= '0;
            retired_q <= '0;
            load_ir_q <= 1'b0;
            load_dr_q <= 1'b0;
            load_pc_q <= 1'b0;
            inc_pc_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            load_rd_q <= 1'b0;
`ifdef SCPU_SINGLE_STEP_EN
            step_ok_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            halted_q  <= halted_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            load_ir_q <= load_ir_d;
            load_dr_q <= load_dr_d;
            load_pc_q <= load_pc_d;
            inc_pc_q  <= inc_pc_d;
            mem_wr_q  <= mem_wr_d;
            load_rd_q <= load_rd_d;
`ifdef SCPU_SINGLE_STEP_EN
            step_ok_q <= step_ok_d;
`endif
        end
    end

    assign ctl_load_ir = load_ir_q;
    assign ctl_load_dr = load_dr_q;
    assign ctl_load_pc = load_pc_q;
    assign ctl_inc_pc  = inc_pc_q;
    assign ctl_mem_wr  = mem_wr_q;
    assign ctl_load_rd = load_rd_q;
    assign ctl_halted  = halted_q;
    assign ctl_err     = err_q;
    assign ctl_state   = state_q;
    assign ctl_retired = retired_q;

endmodule

// File: tb/tb_scpu_ctrl_fsm.sv
// Randomized bench for scpu_ctrl_fsm: each instruction is expanded into a plan of cycle steps
// (memory accesses and fixed cycles) from the opcode class rules, and outputs are compared every cycle.
module tb_scpu_ctrl_fsm;

    localparam int WAIT_MAX = 16;
    localparam int RET_W    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       fetch_ir;
    logic             mem_rdy;
    logic             ctl_load_ir, ctl_load_dr, ctl_load_pc, ctl_inc_pc;
    logic [1:0]       ctl_addr_sel;
    logic             ctl_mem_wr, ctl_load_rd, ctl_halted, ctl_err;
    logic [2:0]       ctl_state;
    logic [RET_W-1:0] ctl_retired;

    scpu_ctrl_fsm #(.WAIT_MAX(WAIT_MAX), .RET_W(RET_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef SCPU_SINGLE_STEP_EN
        .dbg_step_en  (1'b0),
        .dbg_step     (1'b0),
`endif
        .fetch_ir     (fetch_ir),
        .mem_rdy      (mem_rdy),
        .ctl_load_ir  (ctl_load_ir),
        .ctl_load_dr  (ctl_load_dr),
        .ctl_load_pc  (ctl_load_pc),
        .ctl_inc_pc   (ctl_inc_pc),
        .ctl_addr_sel (ctl_addr_sel),
        .ctl_mem_wr   (ctl_mem_wr),
        .ctl_load_rd  (ctl_load_rd),
        .ctl_halted   (ctl_halted),
        .ctl_err      (ctl_err),
        .ctl_state    (ctl_state),
        .ctl_retired  (ctl_retired)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {load_ir, load_dr, load_pc, inc_pc, mem_wr, load_rd}.
    localparam logic [5:0] B_IR  = 6'b100000;
    localparam logic [5:0] B_DR  = 6'b010000;
    localparam logic [5:0] B_PC  = 6'b001000;
    localparam logic [5:0] B_INC = 6'b000100;
    localparam logic [5:0] B_WR  = 6'b000010;
    localparam logic [5:0] B_RD  = 6'b000001;

    typedef enum int {K_ACC, K_FIX, K_STOP} kind_e;
    typedef struct {
        kind_e      kind;   // K_ACC waits for mem_rdy, K_FIX takes one cycle, K_STOP never ends
        int         st;     // state code reported while this step is current
        logic [5:0] stb;    // strobes raised when the step completes
        bit         retire; // instruction retires when this step completes
    } phase_t;

    phase_t           plan[$];
    int               waits;
    logic [RET_W-1:0] retired_m;
    bit               err_m;
    int               exp_state;
    logic [5:0]       exp_stb;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic phase_t ph(kind_e k, int st, logic [5:0] s, bit r);
        phase_t p;
        p.kind = k; p.st = st; p.stb = s; p.retire = r;
        return p;
    endfunction

    task automatic model_reset();
        plan.delete();
        plan.push_back(ph(K_FIX, 0, 6'b0, 1'b0));
        waits     = 0;
        retired_m = '0;
        err_m     = 1'b0;
        exp_state = 0;
        exp_stb   = 6'b0;
    endtask

    task automatic new_instr();
        logic [7:0] ir;
        ir = ($urandom_range(11) == 0) ? 8'hFF : 8'($urandom);
        fetch_ir = ir;
        plan.push_back(ph(K_ACC, 1, B_IR | B_INC, 1'b0));
        plan.push_back(ph(K_FIX, 2, 6'b0, 1'b0));
        if (ir == 8'hFF) begin
            plan.push_back(ph(K_STOP, 7, 6'b0, 1'b0));
        end else begin
            case (ir[7:6])
                2'b00: plan.push_back(ph(K_FIX, 4, B_RD, 1'b1));
                2'b01: begin
                    plan.push_back(ph(K_ACC, 3, B_DR | B_INC, 1'b0));
                    plan.push_back(ph(K_FIX, 4, B_RD, 1'b1));
                end
                2'b10: plan.push_back(ph(K_ACC, 5, ir[5] ? B_WR : B_RD, 1'b1));
                default: begin
                    plan.push_back(ph(K_ACC, 3, B_DR | B_INC, 1'b0));
                    plan.push_back(ph(K_FIX, 6, B_PC, 1'b1));
                end
            endcase
        end
    endtask

    // Predict what the outputs show after the coming edge, given this cycle's mem_rdy.
    task automatic model_step(input bit rdy);
        phase_t p;
        p = plan[0];
        exp_stb = 6'b0;
        if (p.kind == K_FIX || (p.kind == K_ACC && rdy)) begin
            exp_stb = p.stb;
            if (p.retire) retired_m = retired_m + 1'b1;
            void'(plan.pop_front());
            waits = 0;
        end else if (p.kind == K_ACC) begin
            waits++;
            if (waits == WAIT_MAX) begin
                err_m = 1'b1;
                plan.delete();
                plan.push_back(ph(K_STOP, 0, 6'b0, 1'b0));
            end
        end
        exp_state = (plan.size() > 0) ? plan[0].st : 1;
    endtask

    task automatic check_all();
        bit halted_e;
        halted_e = (plan.size() > 0) && (plan[0].kind == K_STOP) && (plan[0].st == 7);
        check("state", 32'(ctl_state), 32'(exp_state));
        check("strobes", 32'({ctl_load_ir, ctl_load_dr, ctl_load_pc, ctl_inc_pc, ctl_mem_wr, ctl_load_rd}),
              32'(exp_stb));
        check("addr_sel", 32'(ctl_addr_sel), (exp_state == 5) ? 32'd2 : 32'd0);
        check("halted", 32'(ctl_halted), 32'(halted_e));
        check("err", 32'(ctl_err), 32'(err_m));
        check("retired", 32'(ctl_retired), 32'(retired_m));
    endtask

    initial begin
        rst_n    = 1'b0;
        mem_rdy  = 1'b0;
        fetch_ir = 8'h00;
        model_reset();
        @(posedge clk);
        for (int seg = 0; seg < 24; seg++) begin
            int  mode, pct, budget, early, post, cyc;
            bit  rdy;
            mode   = seg % 4;
            pct    = (mode == 0) ? 90 : (mode == 1) ? 50 : 25;
            budget = 600;
            early  = ($urandom_range(2) == 0) ? int'($urandom_range(60, 3)) : 0;
            post   = 0;
            cyc    = 0;
            forever begin
                @(negedge clk);
                check_all();
                if (cyc == budget || (early != 0 && cyc == early) || post == 100) begin
                    rst_n   = 1'b0;
                    mem_rdy = 1'($urandom);
                    model_reset();
                    @(posedge clk);
                    break;
                end
                rst_n = 1'b1;
                if (plan.size() == 0) new_instr();
                rdy = (mode == 3) ? 1'b0 : (int'($urandom_range(99)) < pct);
                mem_rdy = rdy;
                model_step(rdy);
                if (plan.size() > 0 && plan[0].kind == K_STOP) post++;
                cyc++;
                @(posedge clk);
            end
        end
        @(negedge clk);
        check_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
